// File: rtl/board_io_hub_if.sv
// Pin-side bundle for board_io_hub: raw switch/button/LED pins, debounced levels and IRQ lines.
// The hub takes the slave modport; whoever drives the raw pins and IRQ controls takes master.
interface board_io_hub_if #(
    parameter int N_SW     = 16,
    parameter int N_BTN    = 5,
    parameter int N_LED    = 16,
    parameter int PWM_BITS = 4
);
    logic [N_SW-1:0]     sw_i;
    logic [N_BTN-1:0]    btn_i;
    logic [N_SW-1:0]     sw_o;
    logic [N_BTN-1:0]    btn_o;
    logic [N_BTN-1:0]    btn_rise_o;
    logic [N_BTN-1:0]    irq_mask_i;
    logic [N_BTN-1:0]    irq_ack_i;
    logic [N_BTN-1:0]    irq_pend_o;
    logic                irq_o;
    logic [N_LED-1:0]    led_i;
    logic [PWM_BITS-1:0] led_pwm_i;
    logic [N_LED-1:0]    led_o;

    modport master (
        output sw_i, btn_i, irq_mask_i, irq_ack_i, led_i, led_pwm_i,
        input  sw_o, btn_o, btn_rise_o, irq_pend_o, irq_o, led_o
    );

    modport slave (
        input  sw_i, btn_i, irq_mask_i, irq_ack_i, led_i, led_pwm_i,
        output sw_o, btn_o, btn_rise_o, irq_pend_o, irq_o, led_o
    );
endinterface

// File: rtl/board_io_hub.sv
// Board I/O conditioning: synchronise and debounce switches/buttons, raise sticky maskable
// button interrupts on accepted rising edges, and drive LEDs through a global PWM dimmer.
module board_io_hub #(
    parameter int N_SW         = 16,
    parameter int N_BTN        = 5,
    parameter int N_LED        = 16,
    parameter int DEBOUNCE_CYC = 100000,
    parameter int PWM_BITS     = 4
) (
    input  logic          clk_i,
    input  logic          srst_i,
    board_io_hub_if.slave io
);
    localparam int N_CH  = N_SW + N_BTN;
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [N_CH-1:0]     sync1_q, sync1_d;
    logic [N_CH-1:0]     sync2_q, sync2_d;
    logic [N_CH-1:0]     stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q [N_CH];
    logic [CNT_W-1:0]    cnt_d [N_CH];
    logic [N_BTN-1:0]    rise_q, rise_d;
    logic [N_BTN-1:0]    pend_q, pend_d;
    logic                irq_q, irq_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0]    led_q, led_d;
    logic                led_on;

    // Switches occupy the low channels, buttons the high ones; all share one debouncer array.
    always_comb begin
        sync1_d  = {io.btn_i, io.sw_i};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // irq_o looks at the registered pending bits, so set, ack and mask all reach it a cycle later.
    always_comb begin
        rise_d    = stable_d[N_CH-1:N_SW] & ~stable_q[N_CH-1:N_SW];
        pend_d    = (pend_q & ~io.irq_ack_i) | rise_d;
        irq_d     = |(pend_q & ~io.irq_mask_i);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        led_on    = (pwm_cnt_q < io.led_pwm_i) || (io.led_pwm_i == '1);
        led_d     = io.led_i & {N_LED{led_on}};
    end

    always_ff @(posedge clk_i) begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        if (srst_i) begin
            stable_q  <= '0;
            cnt_q     <= '{default: '0};
            rise_q    <= '0;
            pend_q    <= '0;
            irq_q     <= 1'b0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            rise_q    <= rise_d;
            pend_q    <= pend_d;
            irq_q     <= irq_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign io.sw_o       = stable_q[N_SW-1:0];
    assign io.btn_o      = stable_q[N_CH-1:N_SW];
    assign io.btn_rise_o = rise_q;
    assign io.irq_pend_o = pend_q;
    assign io.irq_o      = irq_q;
    assign io.led_o      = led_q;
endmodule

// File: tb/tb_board_io_hub.sv
// Directed bench for board_io_hub: a cycle-level behavioural model is compared every cycle,
// and hand-computed expectations pin reset, glitch rejection, masking, ack collision and PWM.
module tb_board_io_hub;
    localparam int N_SW     = 16;
    localparam int N_BTN    = 5;
    localparam int N_LED    = 16;
    localparam int DEB      = 4;
    localparam int PWM_BITS = 2;
    localparam int N_CH     = N_SW + N_BTN;

    logic clk = 1'b0;
    logic srst;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rise0_cnt = 0;
    int rise0_cyc = 0;

    board_io_hub_if #(.N_SW(N_SW), .N_BTN(N_BTN), .N_LED(N_LED), .PWM_BITS(PWM_BITS)) hub_if ();

    board_io_hub #(
        .N_SW(N_SW), .N_BTN(N_BTN), .N_LED(N_LED), .DEBOUNCE_CYC(DEB), .PWM_BITS(PWM_BITS)
    ) dut (
        .clk_i (clk),
        .srst_i(srst),
        .io    (hub_if)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a level is accepted once DEB consecutive synchronised samples disagree with it;
    // synchronised sample = pin value two clock edges earlier.
    logic [N_CH-1:0]  pin_hist[$];
    logic [N_CH-1:0]  m_sync;
    logic [N_CH-1:0]  m_acc;
    int               m_run [N_CH];
    logic [N_BTN-1:0] m_old_btn, m_rise, m_pend;
    logic             m_irq;
    logic [N_LED-1:0] m_led;
    int               m_phase;

    always @(posedge clk) begin
        cyc++;
        m_sync = (pin_hist.size() >= 2) ? pin_hist[1] : '0;
        pin_hist.push_front({hub_if.btn_i, hub_if.sw_i});
        if (pin_hist.size() > 2) void'(pin_hist.pop_back());
        if (srst) begin
            m_acc   = '0;
            for (int i = 0; i < N_CH; i++) m_run[i] = 0;
            m_rise  = '0;
            m_pend  = '0;
            m_irq   = 1'b0;
            m_led   = '0;
            m_phase = 0;
        end else begin
            m_old_btn = m_acc[N_CH-1:N_SW];
            for (int i = 0; i < N_CH; i++) begin
                if (m_sync[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_acc[i] = m_sync[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rise = m_acc[N_CH-1:N_SW] & ~m_old_btn;
            m_irq  = |(m_pend & ~hub_if.irq_mask_i);
            m_pend = (m_pend & ~hub_if.irq_ack_i) | m_rise;
            if (((m_phase % (1 << PWM_BITS)) < int'(hub_if.led_pwm_i)) ||
                (int'(hub_if.led_pwm_i) == (1 << PWM_BITS) - 1))
                m_led = hub_if.led_i;
            else
                m_led = '0;
            m_phase++;
        end
        #1;
        check_output("sw_o",       32'(hub_if.sw_o),       32'(m_acc[N_SW-1:0]));
        check_output("btn_o",      32'(hub_if.btn_o),      32'(m_acc[N_CH-1:N_SW]));
        check_output("btn_rise_o", 32'(hub_if.btn_rise_o), 32'(m_rise));
        check_output("irq_pend_o", 32'(hub_if.irq_pend_o), 32'(m_pend));
        check_output("irq_o",      32'(hub_if.irq_o),      32'(m_irq));
        check_output("led_o",      32'(hub_if.led_o),      32'(m_led));
        if (hub_if.btn_rise_o[0]) begin
            rise0_cnt++;
            rise0_cyc = cyc;
        end
    end

    task automatic measure_pwm(input logic [PWM_BITS-1:0] level, input int exp_high, input string name);
        int high;
        high = 0;
        hub_if.led_pwm_i = level;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (hub_if.led_o == 16'hFFFF) high++;
        end
        check_output(name, 32'(high), 32'(exp_high));
        @(negedge clk);
    endtask

    initial begin : apply_stimulus
        int mark;
        srst              = 1'b1;
        hub_if.sw_i       = 16'h8000;
        hub_if.btn_i      = '0;
        hub_if.irq_mask_i = '0;
        hub_if.irq_ack_i  = '0;
        hub_if.led_i      = '0;
        hub_if.led_pwm_i  = '0;
        tick(4);

        // Buttons held through reset: outputs stay 0, then accepted DEB edges after release.
        hub_if.btn_i = '1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_output("rst_btn_o",  32'(hub_if.btn_o),      32'h0);
            check_output("rst_rise",   32'(hub_if.btn_rise_o), 32'h0);
            check_output("rst_irq",    32'(hub_if.irq_o),      32'h0);
            check_output("rst_sw_o",   32'(hub_if.sw_o),       32'h0);
        end
        @(negedge clk);
        srst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            check_output("rel_btn_o", 32'(hub_if.btn_o),      (c >= 4) ? 32'h1F : 32'h0);
            check_output("rel_rise",  32'(hub_if.btn_rise_o), (c == 4) ? 32'h1F : 32'h0);
            check_output("rel_pend",  32'(hub_if.irq_pend_o), (c >= 4) ? 32'h1F : 32'h0);
            check_output("rel_irq",   32'(hub_if.irq_o),      (c >= 5) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        hub_if.irq_ack_i = '1;
        tick(1);
        hub_if.irq_ack_i = '0;
        hub_if.btn_i     = '0;
        tick(8);

        // Glitch reject on button 0: 3 high, 2 low, then 10 high.
        rise0_cnt = 0;
        hub_if.btn_i[0] = 1'b1;
        tick(3);
        hub_if.btn_i[0] = 1'b0;
        tick(2);
        hub_if.btn_i[0] = 1'b1;
        mark = cyc;
        tick(10);
        check_output("glitch_pulses", 32'(rise0_cnt), 32'd1);
        check_output("glitch_delay",  32'(rise0_cyc - mark), 32'd6);
        hub_if.irq_ack_i = '1;
        tick(1);
        hub_if.irq_ack_i = '0;
        tick(2);

        // Masked channel still pends; unmask and ack each show on irq_o one cycle later.
        hub_if.irq_mask_i = 5'b00010;
        hub_if.btn_i[1]   = 1'b1;
        tick(8);
        check_output("mask_pend", 32'(hub_if.irq_pend_o[1]), 32'h1);
        check_output("mask_irq",  32'(hub_if.irq_o),         32'h0);
        hub_if.irq_mask_i = '0;
        @(posedge clk);
        #1;
        check_output("unmask_irq", 32'(hub_if.irq_o), 32'h1);
        @(negedge clk);
        hub_if.irq_ack_i = 5'b00010;
        @(posedge clk);
        #1;
        check_output("ack_pend",     32'(hub_if.irq_pend_o[1]), 32'h0);
        check_output("ack_irq_lag",  32'(hub_if.irq_o),         32'h1);
        @(negedge clk);
        hub_if.irq_ack_i = '0;
        @(posedge clk);
        #1;
        check_output("ack_irq", 32'(hub_if.irq_o), 32'h0);
        @(negedge clk);

        // Ack collides with the rising-edge pulse on button 2: set wins.
        hub_if.btn_i[2] = 1'b1;
        tick(5);
        hub_if.irq_ack_i = 5'b00100;
        @(posedge clk);
        #1;
        check_output("coll_rise", 32'(hub_if.btn_rise_o[2]), 32'h1);
        check_output("coll_pend", 32'(hub_if.irq_pend_o[2]), 32'h1);
        @(negedge clk);
        hub_if.irq_ack_i = '0;
        @(posedge clk);
        #1;
        check_output("coll_irq", 32'(hub_if.irq_o), 32'h1);
        @(negedge clk);
        hub_if.irq_ack_i = '1;
        tick(1);
        hub_if.irq_ack_i = '0;
        tick(2);

        // Switch 15 release: falls after 6 edges, no button or IRQ side effects.
        hub_if.sw_i[15] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check_output("sw15",     32'(hub_if.sw_o[15]),   (k >= 6) ? 32'h0 : 32'h1);
            check_output("sw_rise",  32'(hub_if.btn_rise_o), 32'h0);
            check_output("sw_irq",   32'(hub_if.irq_o),      32'h0);
        end
        @(negedge clk);

        // PWM duty over two full periods of 4 cycles.
        hub_if.led_i = 16'hFFFF;
        measure_pwm(2'd0, 0, "pwm0_high");
        measure_pwm(2'd1, 2, "pwm1_high");
        measure_pwm(2'd3, 8, "pwm3_high");
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
